// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, function codes, instruction IDs and immediate formats
// shared by the decode stage and its combinational decoder.
package decode_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // func7 patterns
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Frequently used func3 values
    localparam logic [2:0] F3_ZERO = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;

    // The only legal func3=000 SYSTEM words
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    // Minimum instr_id width that holds every ID below
    localparam int unsigned ID_W_MIN = 7;

    typedef enum logic [ID_W_MIN-1:0] {
        ID_INVALID = 7'd0,
        ID_LUI, ID_AUIPC, ID_JAL, ID_JALR,
        ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU, ID_BGEU,
        ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU,
        ID_SB, ID_SH, ID_SW,
        ID_ADDI, ID_SLTI, ID_SLTIU, ID_XORI, ID_ORI, ID_ANDI,
        ID_SLLI, ID_SRLI, ID_SRAI,
        ID_ADD, ID_SUB, ID_SLL, ID_SLT, ID_SLTU, ID_XOR, ID_SRL, ID_SRA, ID_OR, ID_AND,
        ID_FENCE, ID_ECALL, ID_EBREAK,
        ID_CSRRW, ID_CSRRS, ID_CSRRC, ID_CSRRWI, ID_CSRRSI, ID_CSRRCI,
        ID_LD, ID_LWU, ID_SD,
        ID_ADDIW, ID_SLLIW, ID_SRLIW, ID_SRAIW,
        ID_ADDW, ID_SUBW, ID_SLLW, ID_SRLW, ID_SRAW,
        ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU, ID_DIV, ID_DIVU, ID_REM, ID_REMU,
        ID_MULW, ID_DIVW, ID_DIVUW, ID_REMW, ID_REMUW
    } instr_id_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

endpackage

// File: rtl/decode_stage_core.sv
// decode_core: purely combinational RISC-V instruction decoder (RV32I / RV64I).
// Optional M extension decode is enabled by defining DECODE_M_EXT_EN.
module decode_core
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [2:0]      o_func3,
    output logic [6:0]      o_func7,
    output logic [XLEN-1:0] o_imm,
    output logic [5:0]      o_shamt,
    output instr_id_e       o_id,
    output logic            o_illegal,
    output logic            o_uses_rs1,
    output logic            o_uses_rs2,
    output logic            o_writes_rd
);

    localparam bit IS_RV64 = (XLEN == 64);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_sh_base;
    logic        w_sh_alt;
    instr_id_e   w_id;
    imm_fmt_e    w_fmt;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_rd_used;
    logic [31:0] w_imm32;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];

    assign o_rs1   = i_instr[19:15];
    assign o_rs2   = i_instr[24:20];
    assign o_rd    = i_instr[11:7];
    assign o_func3 = w_f3;
    assign o_func7 = w_f7;

    // RV64 immediate shifts carry shamt[5] in instr[25], so only func7[6:1] qualifies them
    assign w_sh_base = IS_RV64 ? (w_f7[6:1] == F7_BASE[6:1]) : (w_f7 == F7_BASE);
    assign w_sh_alt  = IS_RV64 ? (w_f7[6:1] == F7_ALT[6:1])  : (w_f7 == F7_ALT);
    assign o_shamt   = IS_RV64 ? i_instr[25:20] : {1'b0, i_instr[24:20]};

    // Instruction identification, immediate format and operand usage
    always_comb begin
        w_id       = ID_INVALID;
        w_fmt      = IMM_NONE;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_rd_used  = 1'b0;
        case (w_opc)
            OPC_LUI: begin
                w_id = ID_LUI; w_fmt = IMM_U; w_rd_used = 1'b1;
            end
            OPC_AUIPC: begin
                w_id = ID_AUIPC; w_fmt = IMM_U; w_rd_used = 1'b1;
            end
            OPC_JAL: begin
                w_id = ID_JAL; w_fmt = IMM_J; w_rd_used = 1'b1;
            end
            OPC_JALR: begin
                w_fmt = IMM_I; w_rs1_used = 1'b1; w_rd_used = 1'b1;
                if (w_f3 == F3_ZERO) w_id = ID_JALR;
            end
            OPC_BRANCH: begin
                w_fmt = IMM_B; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
                case (w_f3)
                    3'b000:  w_id = ID_BEQ;
                    3'b001:  w_id = ID_BNE;
                    3'b100:  w_id = ID_BLT;
                    3'b101:  w_id = ID_BGE;
                    3'b110:  w_id = ID_BLTU;
                    3'b111:  w_id = ID_BGEU;
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                w_fmt = IMM_I; w_rs1_used = 1'b1; w_rd_used = 1'b1;
                case (w_f3)
                    3'b000:  w_id = ID_LB;
                    3'b001:  w_id = ID_LH;
                    3'b010:  w_id = ID_LW;
                    3'b011:  if (IS_RV64) w_id = ID_LD;
                    3'b100:  w_id = ID_LBU;
                    3'b101:  w_id = ID_LHU;
                    3'b110:  if (IS_RV64) w_id = ID_LWU;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                w_fmt = IMM_S; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
                case (w_f3)
                    3'b000:  w_id = ID_SB;
                    3'b001:  w_id = ID_SH;
                    3'b010:  w_id = ID_SW;
                    3'b011:  if (IS_RV64) w_id = ID_SD;
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                w_fmt = IMM_I; w_rs1_used = 1'b1; w_rd_used = 1'b1;
                case (w_f3)
                    3'b000: w_id = ID_ADDI;
                    3'b010: w_id = ID_SLTI;
                    3'b011: w_id = ID_SLTIU;
                    3'b100: w_id = ID_XORI;
                    3'b110: w_id = ID_ORI;
                    3'b111: w_id = ID_ANDI;
                    3'b001: if (w_sh_base) w_id = ID_SLLI;
                    default: begin
                        if (w_sh_base)     w_id = ID_SRLI;
                        else if (w_sh_alt) w_id = ID_SRAI;
                    end
                endcase
            end
            OPC_OP: begin
                w_rs1_used = 1'b1; w_rs2_used = 1'b1; w_rd_used = 1'b1;
                if (w_f7 == F7_BASE) begin
                    case (w_f3)
                        3'b000:  w_id = ID_ADD;
                        3'b001:  w_id = ID_SLL;
                        3'b010:  w_id = ID_SLT;
                        3'b011:  w_id = ID_SLTU;
                        3'b100:  w_id = ID_XOR;
                        3'b101:  w_id = ID_SRL;
                        3'b110:  w_id = ID_OR;
                        default: w_id = ID_AND;
                    endcase
                end else if (w_f7 == F7_ALT) begin
                    if (w_f3 == F3_ZERO)   w_id = ID_SUB;
                    else if (w_f3 == F3_SR) w_id = ID_SRA;
                end
`ifdef DECODE_M_EXT_EN
                else if (w_f7 == F7_MULDIV) begin
                    case (w_f3)
                        3'b000:  w_id = ID_MUL;
                        3'b001:  w_id = ID_MULH;
                        3'b010:  w_id = ID_MULHSU;
                        3'b011:  w_id = ID_MULHU;
                        3'b100:  w_id = ID_DIV;
                        3'b101:  w_id = ID_DIVU;
                        3'b110:  w_id = ID_REM;
                        default: w_id = ID_REMU;
                    endcase
                end
`endif
            end
            OPC_OP_IMM32: begin
                w_fmt = IMM_I; w_rs1_used = 1'b1; w_rd_used = 1'b1;
                if (IS_RV64) begin
                    if (w_f3 == F3_ZERO)                           w_id = ID_ADDIW;
                    else if (w_f3 == F3_SLL && w_f7 == F7_BASE)    w_id = ID_SLLIW;
                    else if (w_f3 == F3_SR && w_f7 == F7_BASE)     w_id = ID_SRLIW;
                    else if (w_f3 == F3_SR && w_f7 == F7_ALT)      w_id = ID_SRAIW;
                end
            end
            OPC_OP_32: begin
                w_rs1_used = 1'b1; w_rs2_used = 1'b1; w_rd_used = 1'b1;
                if (IS_RV64) begin
                    if (w_f7 == F7_BASE) begin
                        if (w_f3 == F3_ZERO)     w_id = ID_ADDW;
                        else if (w_f3 == F3_SLL) w_id = ID_SLLW;
                        else if (w_f3 == F3_SR)  w_id = ID_SRLW;
                    end else if (w_f7 == F7_ALT) begin
                        if (w_f3 == F3_ZERO)     w_id = ID_SUBW;
                        else if (w_f3 == F3_SR)  w_id = ID_SRAW;
                    end
`ifdef DECODE_M_EXT_EN
                    else if (w_f7 == F7_MULDIV) begin
                        case (w_f3)
                            3'b000:  w_id = ID_MULW;
                            3'b100:  w_id = ID_DIVW;
                            3'b101:  w_id = ID_DIVUW;
                            3'b110:  w_id = ID_REMW;
                            3'b111:  w_id = ID_REMUW;
                            default: ;
                        endcase
                    end
`endif
                end
            end
            OPC_MISC_MEM: begin
                w_fmt = IMM_I;
                if (w_f3 == F3_ZERO) w_id = ID_FENCE;
            end
            OPC_SYSTEM: begin
                w_fmt = IMM_I;
                case (w_f3)
                    3'b000: begin
                        w_fmt = IMM_NONE;
                        if (i_instr == INSTR_ECALL)       w_id = ID_ECALL;
                        else if (i_instr == INSTR_EBREAK) w_id = ID_EBREAK;
                    end
                    3'b001: begin w_id = ID_CSRRW;  w_rs1_used = 1'b1; w_rd_used = 1'b1; end
                    3'b010: begin w_id = ID_CSRRS;  w_rs1_used = 1'b1; w_rd_used = 1'b1; end
                    3'b011: begin w_id = ID_CSRRC;  w_rs1_used = 1'b1; w_rd_used = 1'b1; end
                    3'b101: begin w_id = ID_CSRRWI; w_rd_used = 1'b1; end
                    3'b110: begin w_id = ID_CSRRSI; w_rd_used = 1'b1; end
                    3'b111: begin w_id = ID_CSRRCI; w_rd_used = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        // An unrecognised word carries no operands, no write and no immediate
        if (w_id == ID_INVALID) begin
            w_fmt      = IMM_NONE;
            w_rs1_used = 1'b0;
            w_rs2_used = 1'b0;
            w_rd_used  = 1'b0;
        end
    end

    // Assemble the 32-bit immediate; all formats take their sign from instr[31]
    always_comb begin
        case (w_fmt)
            IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                                i_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                                i_instr[30:21], 1'b0};
            default: w_imm32 = 32'b0;
        endcase
    end

    assign o_imm       = XLEN'($signed(w_imm32));
    assign o_id        = w_id;
    assign o_illegal   = (w_id == ID_INVALID);
    assign o_uses_rs1  = w_rs1_used;
    assign o_uses_rs2  = w_rs2_used;
    assign o_writes_rd = w_rd_used && (i_instr[11:7] != 5'd0);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RISC-V decode stage with valid/ready handshake and flush.
// Define DECODE_M_EXT_EN to decode the M extension (handled inside decode_core).
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ID_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] imm,
    output logic [5:0]      shamt,
    output logic [ID_W-1:0] instr_id,
    output logic            illegal,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            writes_rd
);

    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("decode_stage: XLEN must be 32 or 64");
    end
    if (ID_W < ID_W_MIN) begin : g_bad_id_w
        $error("decode_stage: ID_W too small for decode_pkg IDs");
    end

    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [2:0]      w_func3;
    logic [6:0]      w_func7;
    logic [XLEN-1:0] w_imm;
    logic [5:0]      w_shamt;
    instr_id_e       w_id;
    logic            w_illegal;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_writes_rd;
    logic            w_load;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [2:0]      r_func3;
    logic [6:0]      r_func7;
    logic [XLEN-1:0] r_imm;
    logic [5:0]      r_shamt;
    logic [ID_W-1:0] r_id;
    logic            r_illegal;
    logic            r_uses_rs1;
    logic            r_uses_rs2;
    logic            r_writes_rd;

    decode_core #(
        .XLEN (XLEN)
    ) u_core (
        .i_instr     (in_instr),
        .o_rs1       (w_rs1),
        .o_rs2       (w_rs2),
        .o_rd        (w_rd),
        .o_func3     (w_func3),
        .o_func7     (w_func7),
        .o_imm       (w_imm),
        .o_shamt     (w_shamt),
        .o_id        (w_id),
        .o_illegal   (w_illegal),
        .o_uses_rs1  (w_uses_rs1),
        .o_uses_rs2  (w_uses_rs2),
        .o_writes_rd (w_writes_rd)
    );

    assign in_ready = !r_valid || out_ready;
    // Flush wins over an accept presented in the same cycle
    assign w_load   = in_valid && in_ready && !flush;

    // Valid flag: cleared by flush or by a consume without refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload: loaded only on accept, otherwise held (stable while stalled)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_func3     <= '0;
            r_func7     <= '0;
            r_imm       <= '0;
            r_shamt     <= '0;
            r_id        <= '0;
            r_illegal   <= 1'b0;
            r_uses_rs1  <= 1'b0;
            r_uses_rs2  <= 1'b0;
            r_writes_rd <= 1'b0;
        end else if (w_load) begin
            r_pc        <= in_pc;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_func3     <= w_func3;
            r_func7     <= w_func7;
            r_imm       <= w_imm;
            r_shamt     <= w_shamt;
            r_id        <= ID_W'(w_id);
            r_illegal   <= w_illegal;
            r_uses_rs1  <= w_uses_rs1;
            r_uses_rs2  <= w_uses_rs2;
            r_writes_rd <= w_writes_rd;
        end
    end

    assign out_valid = r_valid;
    assign out_pc    = r_pc;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign rd        = r_rd;
    assign func3     = r_func3;
    assign func7     = r_func7;
    assign imm       = r_imm;
    assign shamt     = r_shamt;
    assign instr_id  = r_id;
    assign illegal   = r_illegal;
    assign uses_rs1  = r_uses_rs1;
    assign uses_rs2  = r_uses_rs2;
    assign writes_rd = r_writes_rd;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench; runs an XLEN=32 and an XLEN=64 instance
// side by side on the same stimulus.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_instr = 32'h0;
    logic [63:0] in_pc = 64'h0;

    logic        a32_in_ready, a32_out_valid, a32_illegal, a32_uses_rs1, a32_uses_rs2;
    logic        a32_writes_rd;
    logic [31:0] a32_out_pc, a32_imm;
    logic [4:0]  a32_rs1, a32_rs2, a32_rd;
    logic [2:0]  a32_func3;
    logic [6:0]  a32_func7, a32_instr_id;
    logic [5:0]  a32_shamt;

    logic        a64_in_ready, a64_out_valid, a64_illegal, a64_uses_rs1, a64_uses_rs2;
    logic        a64_writes_rd;
    logic [63:0] a64_out_pc, a64_imm;
    logic [4:0]  a64_rs1, a64_rs2, a64_rd;
    logic [2:0]  a64_func3;
    logic [6:0]  a64_func7, a64_instr_id;
    logic [5:0]  a64_shamt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .ID_W(7)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a32_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a32_out_valid),
        .out_ready(out_ready), .out_pc(a32_out_pc), .rs1(a32_rs1), .rs2(a32_rs2), .rd(a32_rd),
        .func3(a32_func3), .func7(a32_func7), .imm(a32_imm), .shamt(a32_shamt),
        .instr_id(a32_instr_id), .illegal(a32_illegal), .uses_rs1(a32_uses_rs1),
        .uses_rs2(a32_uses_rs2), .writes_rd(a32_writes_rd)
    );

    decode_stage #(.XLEN(64), .ID_W(7)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a64_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(a64_out_valid),
        .out_ready(out_ready), .out_pc(a64_out_pc), .rs1(a64_rs1), .rs2(a64_rs2), .rd(a64_rd),
        .func3(a64_func3), .func7(a64_func7), .imm(a64_imm), .shamt(a64_shamt),
        .instr_id(a64_instr_id), .illegal(a64_illegal), .uses_rs1(a64_uses_rs1),
        .uses_rs2(a64_uses_rs2), .writes_rd(a64_writes_rd)
    );

    // Present one instruction for a single cycle; returns at the negedge after acceptance
    task automatic present(input logic [31:0] ins, input logic [63:0] pc);
        @(negedge clk);
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (a32_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst valid32: got %b want 0", a32_out_valid); end
        n_checks++; if (a64_out_pc !== 64'h0) begin n_fail++; $display("FAIL rst pc64: got %h want 0", a64_out_pc); end
        n_checks++; if (a32_instr_id !== ID_INVALID) begin n_fail++; $display("FAIL rst id32: got %0d want 0", a32_instr_id); end
        n_checks++; if (a64_illegal !== 1'b0) begin n_fail++; $display("FAIL rst illegal64: got %b want 0", a64_illegal); end
        n_checks++; if (a64_imm !== 64'h0) begin n_fail++; $display("FAIL rst imm64: got %h want 0", a64_imm); end
        n_checks++; if (a32_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst in_ready32: got %b want 1", a32_in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (a32_out_valid !== 1'b0) begin n_fail++; $display("FAIL post-rst valid32: got %b want 0", a32_out_valid); end
    endtask

    task automatic test_addi();
        present(32'hFFF0_0093, 64'h1000);
        n_checks++; if (a32_out_valid !== 1'b1) begin n_fail++; $display("FAIL addi valid: got %b want 1", a32_out_valid); end
        n_checks++; if (a32_instr_id !== ID_ADDI) begin n_fail++; $display("FAIL addi id: got %0d want %0d", a32_instr_id, ID_ADDI); end
        n_checks++; if (a32_rd !== 5'd1) begin n_fail++; $display("FAIL addi rd: got %0d want 1", a32_rd); end
        n_checks++; if (a32_imm !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addi imm32: got %h want ffffffff", a32_imm); end
        n_checks++; if (a64_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL addi imm64: got %h want all ones", a64_imm); end
        n_checks++; if (a32_uses_rs1 !== 1'b1) begin n_fail++; $display("FAIL addi uses_rs1: got %b want 1", a32_uses_rs1); end
        n_checks++; if (a32_uses_rs2 !== 1'b0) begin n_fail++; $display("FAIL addi uses_rs2: got %b want 0", a32_uses_rs2); end
        n_checks++; if (a32_writes_rd !== 1'b1) begin n_fail++; $display("FAIL addi writes_rd: got %b want 1", a32_writes_rd); end
        n_checks++; if (a32_out_pc !== 32'h1000) begin n_fail++; $display("FAIL addi pc: got %h want 1000", a32_out_pc); end
        n_checks++; if (a32_func3 !== 3'b000 || a32_func7 !== 7'h7F) begin n_fail++; $display("FAIL addi f3/f7: got %b/%b want 000/1111111", a32_func3, a32_func7); end
        @(negedge clk);
        n_checks++; if (a32_out_valid !== 1'b0) begin n_fail++; $display("FAIL addi drain: got %b want 0", a32_out_valid); end
    endtask

    task automatic test_lui_jal();
        present(32'h8000_02B7, 64'h8000_0000_0000_2000);
        n_checks++; if (a64_instr_id !== ID_LUI) begin n_fail++; $display("FAIL lui id: got %0d want %0d", a64_instr_id, ID_LUI); end
        n_checks++; if (a64_imm !== 64'hFFFF_FFFF_8000_0000) begin n_fail++; $display("FAIL lui imm64: got %h want ffffffff80000000", a64_imm); end
        n_checks++; if (a32_imm !== 32'h8000_0000) begin n_fail++; $display("FAIL lui imm32: got %h want 80000000", a32_imm); end
        n_checks++; if (a64_uses_rs1 !== 1'b0) begin n_fail++; $display("FAIL lui uses_rs1: got %b want 0", a64_uses_rs1); end
        n_checks++; if (a64_rd !== 5'd5) begin n_fail++; $display("FAIL lui rd: got %0d want 5", a64_rd); end
        n_checks++; if (a64_out_pc !== 64'h8000_0000_0000_2000) begin n_fail++; $display("FAIL lui pc64: got %h want 8000000000002000", a64_out_pc); end
        present(32'hFFDF_F0EF, 64'h2004);
        n_checks++; if (a64_instr_id !== ID_JAL) begin n_fail++; $display("FAIL jal id: got %0d want %0d", a64_instr_id, ID_JAL); end
        n_checks++; if (a64_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL jal imm64: got %h want -4", a64_imm); end
        n_checks++; if (a32_imm !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL jal imm32: got %h want -4", a32_imm); end
        n_checks++; if (a64_rd !== 5'd1 || a64_writes_rd !== 1'b1) begin n_fail++; $display("FAIL jal rd/wr: got %0d/%b want 1/1", a64_rd, a64_writes_rd); end
        n_checks++; if (a64_uses_rs1 !== 1'b0) begin n_fail++; $display("FAIL jal uses_rs1: got %b want 0", a64_uses_rs1); end
    endtask

    task automatic test_system();
        present(32'h0000_0073, 64'h3000);
        n_checks++; if (a32_instr_id !== ID_ECALL) begin n_fail++; $display("FAIL ecall id: got %0d want %0d", a32_instr_id, ID_ECALL); end
        n_checks++; if (a32_writes_rd !== 1'b0 || a32_illegal !== 1'b0) begin n_fail++; $display("FAIL ecall wr/ill: got %b/%b want 0/0", a32_writes_rd, a32_illegal); end
        present(32'h0010_0073, 64'h3004);
        n_checks++; if (a64_instr_id !== ID_EBREAK) begin n_fail++; $display("FAIL ebreak id: got %0d want %0d", a64_instr_id, ID_EBREAK); end
        n_checks++; if (a64_writes_rd !== 1'b0 || a64_uses_rs1 !== 1'b0) begin n_fail++; $display("FAIL ebreak wr/rs1: got %b/%b want 0/0", a64_writes_rd, a64_uses_rs1); end
        present(32'h0020_0073, 64'h3008);
        n_checks++; if (a32_illegal !== 1'b1 || a32_instr_id !== ID_INVALID) begin n_fail++; $display("FAIL sys-bad ill/id: got %b/%0d want 1/0", a32_illegal, a32_instr_id); end
        n_checks++; if (a32_out_valid !== 1'b1 || a32_writes_rd !== 1'b0) begin n_fail++; $display("FAIL sys-bad valid/wr: got %b/%b want 1/0", a32_out_valid, a32_writes_rd); end
        n_checks++; if (a32_out_pc !== 32'h3008) begin n_fail++; $display("FAIL sys-bad pc: got %h want 3008", a32_out_pc); end
        // csrrw x1, 0x300, x2
        present(32'h3001_10F3, 64'h300C);
        n_checks++; if (a32_instr_id !== ID_CSRRW) begin n_fail++; $display("FAIL csrrw id: got %0d want %0d", a32_instr_id, ID_CSRRW); end
        n_checks++; if (a32_uses_rs1 !== 1'b1 || a32_writes_rd !== 1'b1) begin n_fail++; $display("FAIL csrrw rs1/wr: got %b/%b want 1/1", a32_uses_rs1, a32_writes_rd); end
    endtask

    task automatic test_shift();
        present(32'h0200_9093, 64'h4000);
        n_checks++; if (a32_illegal !== 1'b1 || a32_instr_id !== ID_INVALID) begin n_fail++; $display("FAIL slli32 ill/id: got %b/%0d want 1/0", a32_illegal, a32_instr_id); end
        n_checks++; if (a32_writes_rd !== 1'b0 || a32_uses_rs1 !== 1'b0) begin n_fail++; $display("FAIL slli32 wr/rs1: got %b/%b want 0/0", a32_writes_rd, a32_uses_rs1); end
        n_checks++; if (a32_shamt !== 6'd0) begin n_fail++; $display("FAIL slli32 shamt: got %0d want 0", a32_shamt); end
        n_checks++; if (a64_instr_id !== ID_SLLI || a64_illegal !== 1'b0) begin n_fail++; $display("FAIL slli64 id/ill: got %0d/%b want %0d/0", a64_instr_id, a64_illegal, ID_SLLI); end
        n_checks++; if (a64_shamt !== 6'd32) begin n_fail++; $display("FAIL slli64 shamt: got %0d want 32", a64_shamt); end
        n_checks++; if (a64_rs1 !== 5'd1 || a64_rd !== 5'd1) begin n_fail++; $display("FAIL slli64 rs1/rd: got %0d/%0d want 1/1", a64_rs1, a64_rd); end
        // srai x1, x1, 32
        present(32'h4200_D093, 64'h4004);
        n_checks++; if (a64_instr_id !== ID_SRAI || a64_shamt !== 6'd32) begin n_fail++; $display("FAIL srai64 id/shamt: got %0d/%0d want %0d/32", a64_instr_id, a64_shamt, ID_SRAI); end
        n_checks++; if (a32_illegal !== 1'b1) begin n_fail++; $display("FAIL srai32 illegal: got %b want 1", a32_illegal); end
    endtask

    task automatic test_rtype();
        // add x3, x1, x2
        present(32'h0020_81B3, 64'h5000);
        n_checks++; if (a32_instr_id !== ID_ADD || a32_imm !== 32'h0) begin n_fail++; $display("FAIL add id/imm: got %0d/%h want %0d/0", a32_instr_id, a32_imm, ID_ADD); end
        n_checks++; if (a32_uses_rs2 !== 1'b1 || a32_rs2 !== 5'd2 || a64_func7 !== 7'h00) begin n_fail++; $display("FAIL add rs2: got %b/%0d/%h want 1/2/00", a32_uses_rs2, a32_rs2, a64_func7); end
        // mul x0, x1, x2
        present(32'h0220_8033, 64'h5004);
`ifdef DECODE_M_EXT_EN
        n_checks++; if (a32_instr_id !== ID_MUL || a32_illegal !== 1'b0) begin n_fail++; $display("FAIL mul id/ill: got %0d/%b want %0d/0", a32_instr_id, a32_illegal, ID_MUL); end
        n_checks++; if (a32_writes_rd !== 1'b0 || a32_uses_rs2 !== 1'b1) begin n_fail++; $display("FAIL mul wr/rs2: got %b/%b want 0/1", a32_writes_rd, a32_uses_rs2); end
`else
        n_checks++; if (a32_instr_id !== ID_INVALID || a32_illegal !== 1'b1) begin n_fail++; $display("FAIL mul id/ill: got %0d/%b want 0/1", a32_instr_id, a32_illegal); end
        n_checks++; if (a64_illegal !== 1'b1 || a64_uses_rs2 !== 1'b0) begin n_fail++; $display("FAIL mul64 ill/rs2: got %b/%b want 1/0", a64_illegal, a64_uses_rs2); end
`endif
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 64'h100;  // addi x1,x0,1
        @(negedge clk);
        in_instr = 32'h0020_0113; in_pc = 64'h104;                   // addi x2,x0,2
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (a32_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b stall ready[%0d]: got %b want 0", k, a32_in_ready); end
            n_checks++; if (a32_out_valid !== 1'b1 || a32_out_pc !== 32'h100 || a32_imm !== 32'd1) begin n_fail++; $display("FAIL b2b frozen[%0d]: got %b/%h/%h want 1/100/1", k, a32_out_valid, a32_out_pc, a32_imm); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (a32_in_ready !== 1'b1 || a32_out_pc !== 32'h100) begin n_fail++; $display("FAIL b2b release: got %b/%h want 1/100", a32_in_ready, a32_out_pc); end
        @(negedge clk);
        n_checks++; if (a32_out_valid !== 1'b1 || a32_out_pc !== 32'h104 || a32_rd !== 5'd2) begin n_fail++; $display("FAIL b2b second: got %b/%h/%0d want 1/104/2", a32_out_valid, a32_out_pc, a32_rd); end
        in_instr = 32'h0030_0193; in_pc = 64'h108;                   // addi x3,x0,3
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (a64_out_valid !== 1'b1 || a64_out_pc !== 64'h108 || a64_imm !== 64'd3) begin n_fail++; $display("FAIL b2b third: got %b/%h/%h want 1/108/3", a64_out_valid, a64_out_pc, a64_imm); end
        @(negedge clk);
        n_checks++; if (a32_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b empty: got %b want 0", a32_out_valid); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h0050_0293; in_pc = 64'h300;  // addi x5,x0,5
        out_ready = 1'b0;
        @(negedge clk);
        in_instr = 32'h0060_0313; in_pc = 64'h304;
        n_checks++; if (a32_out_valid !== 1'b1 || a32_out_pc !== 32'h300) begin n_fail++; $display("FAIL flush held: got %b/%h want 1/300", a32_out_valid, a32_out_pc); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (a32_out_valid !== 1'b0 || a64_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush stall: got %b/%b want 0/0", a32_out_valid, a64_out_valid); end
        @(negedge clk);
        n_checks++; if (a32_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush no-replay: got %b want 0", a32_out_valid); end
        // Flush and a fresh accept in the same cycle: the instruction is dropped
        in_valid = 1'b1; in_instr = 32'h0070_0393; in_pc = 64'h308; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        n_checks++; if (a32_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush priority: got %b want 0", a32_out_valid); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h0080_0413; in_pc = 64'h400;  // addi x8,x0,8
        @(negedge clk);
        n_checks++; if (a32_out_valid !== 1'b1) begin n_fail++; $display("FAIL arst pre valid: got %b want 1", a32_out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (a32_out_valid !== 1'b0 || a64_out_valid !== 1'b0) begin n_fail++; $display("FAIL arst valid: got %b/%b want 0/0", a32_out_valid, a64_out_valid); end
        n_checks++; if (a32_out_pc !== 32'h0 || a32_instr_id !== ID_INVALID || a32_imm !== 32'h0) begin n_fail++; $display("FAIL arst fields: got %h/%0d/%h want 0/0/0", a32_out_pc, a32_instr_id, a32_imm); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (a32_out_valid !== 1'b0) begin n_fail++; $display("FAIL arst after: got %b want 0", a32_out_valid); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lui_jal();
        test_system();
        test_shift();
        test_rtype();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
